// File: rtl/fifo_rd_packer.sv
// Pops entries from a first-word-fall-through FIFO read port and packs PACK of them
// into one wide word on a valid/ready stream; flush emits a partial word with keep bits.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int PACK  = 4
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DSIZE-1:0]      rdata,
    output logic                  rinc,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DSIZE*PACK-1:0] m_data,
    output logic [PACK-1:0]       m_keep,
    output logic [15:0]           word_cnt
);
    localparam int CW = $clog2(PACK);
    localparam int PW = $clog2(PACK + 1);
    localparam logic [CW-1:0] LAST = CW'(PACK - 1);

    logic [CW-1:0]         cnt_reg, cnt_next;
    logic                  flush_pend_reg, flush_pend_next;
    logic                  m_valid_reg, m_valid_next;
    logic [DSIZE*PACK-1:0] m_data_reg, m_data_next;
    logic [PACK-1:0]       m_keep_reg, m_keep_next;
    logic [15:0]           word_cnt_reg;

    logic                  pop;
    logic                  xfer;
    logic                  out_free;
    logic                  load;
    logic [PW-1:0]         p_now;
    logic [DSIZE*PACK-1:0] emit_data;
    logic [PACK-1:0]       emit_keep;

    assign xfer     = m_valid_reg & m_ready;
    assign out_free = ~m_valid_reg | m_ready;

    // The final lane may only pop when the output register can take the word this edge.
    assign rinc  = ~rrst & ~rempty & ~flush_pend_reg & ((cnt_reg != LAST) | out_free);
    assign pop   = rinc;
    assign p_now = PW'(cnt_reg) + PW'(pop);

    genvar gi;
    generate
        for (gi = 0; gi < PACK; gi++) begin : g_lane
            logic [DSIZE-1:0] lane_held;
            if (gi < PACK - 1) begin : g_asm
                logic [DSIZE-1:0] asm_lane_reg;
                always_ff @(posedge rclk) begin
                    if (rrst) begin
                        asm_lane_reg <= '0;
                    end else if (pop && cnt_reg == CW'(gi)) begin
                        asm_lane_reg <= rdata;
                    end
                end
                assign lane_held = asm_lane_reg;
            end else begin : g_top
                assign lane_held = '0;
            end
            // The entry popped on this edge bypasses the assembly register.
            assign emit_keep[gi] = (PW'(gi) < p_now);
            assign emit_data[gi*DSIZE +: DSIZE] =
                emit_keep[gi] ? ((pop && cnt_reg == CW'(gi)) ? rdata : lane_held) : '0;
        end
    endgenerate

    always_comb begin
        load            = 1'b0;
        cnt_next        = cnt_reg;
        flush_pend_next = flush_pend_reg;
        if (flush_pend_reg) begin
            if (out_free) begin
                load            = 1'b1;
                cnt_next        = '0;
                flush_pend_next = 1'b0;
            end
        end else if (pop && cnt_reg == LAST) begin
            load     = 1'b1;
            cnt_next = '0;
        end else if (flush && p_now != '0) begin
            if (out_free) begin
                load     = 1'b1;
                cnt_next = '0;
            end else begin
                cnt_next        = CW'(p_now);
                flush_pend_next = 1'b1;
            end
        end else if (pop) begin
            cnt_next = cnt_reg + CW'(1);
        end
    end

    always_comb begin
        m_valid_next = m_valid_reg & ~m_ready;
        m_data_next  = m_data_reg;
        m_keep_next  = m_keep_reg;
        if (load) begin
            m_valid_next = 1'b1;
            m_data_next  = emit_data;
            m_keep_next  = emit_keep;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt_reg        <= '0;
            flush_pend_reg <= 1'b0;
            m_valid_reg    <= 1'b0;
            m_data_reg     <= '0;
            m_keep_reg     <= '0;
            word_cnt_reg   <= '0;
        end else begin
            cnt_reg        <= cnt_next;
            flush_pend_reg <= flush_pend_next;
            m_valid_reg    <= m_valid_next;
            m_data_reg     <= m_data_next;
            m_keep_reg     <= m_keep_next;
            if (xfer) begin
                word_cnt_reg <= word_cnt_reg + 16'd1;
            end
        end
    end

    assign m_valid  = m_valid_reg;
    assign m_data   = m_data_reg;
    assign m_keep   = m_keep_reg;
    assign word_cnt = word_cnt_reg;
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-backed FIFO, a queue-based packing model and
// directed plus randomized scenarios.
module tb_fifo_rd_packer;
    localparam int D = 8;
    localparam int P = 4;

    logic           rclk = 1'b0;
    logic           rrst;
    logic           rempty;
    logic [D-1:0]   rdata;
    logic           rinc;
    logic           flush;
    logic           m_valid;
    logic           m_ready;
    logic [D*P-1:0] m_data;
    logic [P-1:0]   m_keep;
    logic [15:0]    word_cnt;

    fifo_rd_packer #(.DSIZE(D), .PACK(P)) dut (
        .rclk(rclk), .rrst(rrst), .rempty(rempty), .rdata(rdata), .rinc(rinc),
        .flush(flush), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_keep(m_keep), .word_cnt(word_cnt)
    );

    always #5 rclk = ~rclk;

    int errors = 0;
    int checks = 0;
    int pops   = 0;

    logic [D-1:0]     fifo_q[$];
    logic [D*P+P-1:0] dut_acc[$];

    // reference model: entries collected so far, one output slot, pending flag
    logic [D-1:0]   mdl_part[$];
    logic           mdl_ov;
    logic           mdl_pend;
    logic [D*P-1:0] mdl_data;
    logic [P-1:0]   mdl_keep;
    logic [15:0]    mdl_wc;

    task automatic model_clear();
        mdl_part.delete();
        mdl_ov   = 1'b0;
        mdl_pend = 1'b0;
        mdl_data = '0;
        mdl_keep = '0;
        mdl_wc   = '0;
    endtask

    function automatic logic [D*P+P-1:0] acc_at(int k);
        if (k < dut_acc.size()) return dut_acc[k];
        return 'x;
    endfunction

    task automatic cycle();
        logic exp_rinc, fired, mr, fl, rs, xfer, free, load;
        logic [D-1:0] head;
        rempty = (fifo_q.size() == 0);
        head   = rempty ? '0 : fifo_q[0];
        rdata  = head;
        #1;
        mr = m_ready;
        fl = flush;
        rs = rrst;
        exp_rinc = !rs && !rempty && !mdl_pend &&
                   (mdl_part.size() != P - 1 || !mdl_ov || mr);
        checks++;
        if (rinc !== exp_rinc) begin
            errors++;
            $display("FAIL rinc: got %b expected %b at %0t", rinc, exp_rinc, $time);
        end
        checks++;
        if (rinc === 1'b1 && rempty) begin
            errors++;
            $display("FAIL rinc_while_empty: got rinc=%b expected 0 at %0t", rinc, $time);
        end
        fired = (rinc === 1'b1);
        if (m_valid === 1'b1 && mr) dut_acc.push_back({m_data, m_keep});

        if (rs) begin
            model_clear();
        end else begin
            xfer = mdl_ov && mr;
            free = !mdl_ov || mr;
            load = 1'b0;
            if (xfer) mdl_wc = mdl_wc + 16'd1;
            if (exp_rinc) mdl_part.push_back(head);
            if (mdl_pend) begin
                if (free) begin
                    load     = 1'b1;
                    mdl_pend = 1'b0;
                end
            end else if (mdl_part.size() == P) begin
                load = 1'b1;
            end else if (fl && mdl_part.size() > 0) begin
                if (free) load = 1'b1;
                else mdl_pend = 1'b1;
            end
            if (load) begin
                mdl_data = '0;
                mdl_keep = '0;
                foreach (mdl_part[i]) begin
                    mdl_data[i*D +: D] = mdl_part[i];
                    mdl_keep[i] = 1'b1;
                end
                mdl_part.delete();
                mdl_ov = 1'b1;
            end else if (xfer) begin
                mdl_ov = 1'b0;
            end
        end

        @(posedge rclk);
        if (fired && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        @(negedge rclk);
        flush = 1'b0;

        checks++;
        if (m_valid !== mdl_ov) begin
            errors++;
            $display("FAIL m_valid: got %b expected %b at %0t", m_valid, mdl_ov, $time);
        end
        if (mdl_ov) begin
            checks++;
            if (m_data !== mdl_data) begin
                errors++;
                $display("FAIL m_data: got %h expected %h at %0t", m_data, mdl_data, $time);
            end
            checks++;
            if (m_keep !== mdl_keep) begin
                errors++;
                $display("FAIL m_keep: got %h expected %h at %0t", m_keep, mdl_keep, $time);
            end
        end
        checks++;
        if (word_cnt !== mdl_wc) begin
            errors++;
            $display("FAIL word_cnt: got %0d expected %0d at %0t", word_cnt, mdl_wc, $time);
        end
    endtask

    task automatic do_reset();
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        fifo_q.delete();
        dut_acc.delete();
        pops = 0;
    endtask

    task automatic test_reset();
        fifo_q.push_back(8'h5A);
        rrst    = 1'b1;
        m_ready = 1'b1;
        cycle();
        cycle();
        checks++;
        if (m_valid !== 1'b0 || m_keep !== '0 || m_data !== '0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b d=%h k=%h wc=%0d expected all zero",
                     m_valid, m_data, m_keep, word_cnt);
        end
        checks++;
        if (pops !== 0) begin
            errors++;
            $display("FAIL reset_no_pop: got %0d pops expected 0", pops);
        end
        rrst = 1'b0;
        fifo_q.delete();
        pops = 0;
    endtask

    task automatic test_full_words();
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'((i + 1) * 17));
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c == 7) begin
                checks++;
                if (pops !== 8) begin
                    errors++;
                    $display("FAIL full_consecutive_pops: got %0d expected 8", pops);
                end
            end
        end
        checks++;
        if (acc_at(0) !== {32'h44332211, 4'hF}) begin
            errors++;
            $display("FAIL full_word0: got %h expected %h", acc_at(0), {32'h44332211, 4'hF});
        end
        checks++;
        if (acc_at(1) !== {32'h88776655, 4'hF}) begin
            errors++;
            $display("FAIL full_word1: got %h expected %h", acc_at(1), {32'h88776655, 4'hF});
        end
        checks++;
        if (word_cnt !== 16'd2) begin
            errors++;
            $display("FAIL full_word_cnt: got %0d expected 2", word_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [D*P-1:0] held;
        held = '0;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'((i + 1) * 17));
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (c == 4) held = m_data;
        end
        checks++;
        if (pops !== 7) begin
            errors++;
            $display("FAIL bp_pops_before_ready: got %0d expected 7", pops);
        end
        checks++;
        if (m_data !== held || m_data !== 32'h44332211) begin
            errors++;
            $display("FAIL bp_held_word: got %h expected 44332211", m_data);
        end
        m_ready = 1'b1;
        cycle();
        checks++;
        if (pops !== 8) begin
            errors++;
            $display("FAIL bp_last_pop_on_ready: got %0d expected 8", pops);
        end
        repeat (6) cycle();
        checks++;
        if (acc_at(0) !== {32'h44332211, 4'hF} || acc_at(1) !== {32'h88776655, 4'hF}) begin
            errors++;
            $display("FAIL bp_words: got %h,%h expected 44332211f,88776655f", acc_at(0), acc_at(1));
        end
        checks++;
        if (word_cnt !== 16'd2) begin
            errors++;
            $display("FAIL bp_word_cnt: got %0d expected 2", word_cnt);
        end
    endtask

    task automatic test_flush_partial();
        do_reset();
        m_ready = 1'b1;
        fifo_q.push_back(8'hAA);
        fifo_q.push_back(8'hBB);
        repeat (3) cycle();
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL fp_no_word_before_flush: got m_valid=%b expected 0", m_valid);
        end
        flush = 1'b1;
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h0000BBAA || m_keep !== 4'h3) begin
            errors++;
            $display("FAIL fp_partial: got v=%b d=%h k=%h expected 1 0000bbaa 3", m_valid, m_data, m_keep);
        end
        cycle();
        flush = 1'b1;
        cycle();
        repeat (2) cycle();
        checks++;
        if (word_cnt !== 16'd1 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL fp_empty_flush_ignored: got wc=%0d v=%b expected 1 0", word_cnt, m_valid);
        end
        for (int i = 1; i <= 4; i++) fifo_q.push_back(8'(i * 17));
        repeat (6) cycle();
        checks++;
        if (acc_at(1) !== {32'h44332211, 4'hF}) begin
            errors++;
            $display("FAIL fp_lane0_restart: got %h expected 44332211f", acc_at(1));
        end
    endtask

    task automatic test_flush_same_edge();
        do_reset();
        m_ready = 1'b1;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        cycle();
        cycle();
        flush = 1'b1;
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h00030201 || m_keep !== 4'h7) begin
            errors++;
            $display("FAIL fse_partial: got v=%b d=%h k=%h expected 1 00030201 7", m_valid, m_data, m_keep);
        end
        checks++;
        if (pops !== 3) begin
            errors++;
            $display("FAIL fse_pops: got %0d expected 3", pops);
        end
    endtask

    task automatic test_flush_stalled();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h10 + i));
        repeat (6) cycle();
        checks++;
        if (pops !== 6) begin
            errors++;
            $display("FAIL fst_pops: got %0d expected 6", pops);
        end
        flush = 1'b1;
        cycle();
        fifo_q.push_back(8'h16);
        fifo_q.push_back(8'h17);
        flush = 1'b1;
        cycle();
        cycle();
        checks++;
        if (pops !== 6) begin
            errors++;
            $display("FAIL fst_stall_pops: got %0d pops expected 6 while flush pending", pops);
        end
        checks++;
        if (m_data !== 32'h13121110) begin
            errors++;
            $display("FAIL fst_held: got %h expected 13121110", m_data);
        end
        m_ready = 1'b1;
        cycle();
        checks++;
        if (m_valid !== 1'b1 || m_data !== 32'h00001514 || m_keep !== 4'h3) begin
            errors++;
            $display("FAIL fst_partial: got v=%b d=%h k=%h expected 1 00001514 3", m_valid, m_data, m_keep);
        end
        repeat (4) cycle();
        flush = 1'b1;
        cycle();
        repeat (2) cycle();
        checks++;
        if (acc_at(0) !== {32'h13121110, 4'hF} || acc_at(1) !== {32'h00001514, 4'h3} ||
            acc_at(2) !== {32'h00001716, 4'h3}) begin
            errors++;
            $display("FAIL fst_words: got %h,%h,%h expected 13121110f,000015143,000017163",
                     acc_at(0), acc_at(1), acc_at(2));
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h20 + i));
        repeat (6) cycle();
        checks++;
        if (m_valid !== 1'b1) begin
            errors++;
            $display("FAIL rm_word_held: got m_valid=%b expected 1", m_valid);
        end
        rrst = 1'b1;
        cycle();
        rrst = 1'b0;
        checks++;
        if (m_valid !== 1'b0 || m_data !== '0 || m_keep !== '0 || word_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rm_outputs: got v=%b d=%h k=%h wc=%0d expected all zero",
                     m_valid, m_data, m_keep, word_cnt);
        end
        checks++;
        if (fifo_q.size() !== 2) begin
            errors++;
            $display("FAIL rm_fifo_untouched: got %0d entries expected 2", fifo_q.size());
        end
        fifo_q.push_back(8'h30);
        fifo_q.push_back(8'h31);
        m_ready = 1'b1;
        repeat (6) cycle();
        checks++;
        if (acc_at(0) !== {32'h31302726, 4'hF}) begin
            errors++;
            $display("FAIL rm_clean_word: got %h expected 31302726f", acc_at(0));
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 45 && fifo_q.size() < 16) fifo_q.push_back(8'($urandom));
            m_ready = ($urandom_range(0, 99) < 65);
            flush   = ($urandom_range(0, 99) < 6);
            rrst    = ($urandom_range(0, 999) < 5);
            cycle();
        end
        rrst = 1'b0;
        m_ready = 1'b1;
        repeat (20) cycle();
    endtask

    initial begin
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b0;
        rempty  = 1'b1;
        rdata   = '0;
        model_clear();
        @(negedge rclk);
        test_reset();
        test_full_words();
        test_backpressure();
        test_flush_partial();
        test_flush_same_edge();
        test_flush_stalled();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side consumer for the async `fifo` used in the memory-controller datapath. It pops `DSIZE`-bit entries from the FIFO read port in the `rclk` domain and packs `PACK` consecutive entries into one wide word. The word is presented on a valid/ready stream toward the DDR4 write-data path. A flush request emits a partially filled word with per-lane keep bits.

## Interface
- `DSIZE`, 8: FIFO entry width in bits.
- `PACK`, 4: entries per output word, ≥2.
- `rclk` in 1: read-domain clock; single clock for the whole block.
- `rrst` in 1: synchronous, active-high reset.
- `rempty` in 1: FIFO empty flag. When low, `rdata` already holds the head entry (first-word fall-through).
- `rdata` in DSIZE: FIFO head entry.
- `rinc` out 1: pop strobe. The FIFO advances on the `rclk` edge where `rinc=1`.
- `flush` in 1: single-cycle request to emit the partial word.
- `m_valid` out 1: output word valid.
- `m_ready` in 1: downstream accept.
- `m_data` out DSIZE*PACK: packed word. The first popped entry is in lane 0, bits [DSIZE-1:0].
- `m_keep` out PACK: lane-valid mask, one bit per lane.
- `word_cnt` out 16: count of accepted output words; wraps at 2^16.

## Operation
- State consists of:
  - lane counter `cnt` (0..PACK-1),
  - assembly register holding lanes 0..PACK-2,
  - output register (`m_data`, `m_keep`, `m_valid`),
  - `flush_pend` flag.
- A pop occurs when `rinc=1` on an `rclk` edge. Every pop with `rempty=0` is a real pop.
- Pop rule: `rinc = ~rempty & ~flush_pend & (cnt != PACK-1 | ~m_valid | m_ready)`.
  - This is combinational from registered/flag inputs.
  - `rinc` is never 1 while `rempty=1` or `rrst=1`.
- Pop with `cnt < PACK-1`: store `rdata` in lane `cnt`, then `cnt++`.
- Pop with `cnt == PACK-1`: load the output register directly with `{rdata, assembly}`, set `m_keep` to all ones, set `m_valid=1`, then `cnt=0`.
- Output handshake:
  - A transfer occurs when `m_valid & m_ready`.
  - After a transfer, `m_valid` drops unless a new word loads on the same edge (back-to-back allowed).
  - `m_data` and `m_keep` are held stable while `m_valid & ~m_ready`.
- Flush:
  - Partial count is `p = cnt`, plus 1 if a pop occurs on the same edge (the popped entry is included).
  - If `p == 0`, flush is ignored. If `p == PACK`, it is a normal full word and the flush is consumed.
  - Otherwise, emit lanes 0..p-1 with `m_keep = (1<<p)-1`, unfilled lanes zero, then `cnt=0`.
  - If the output register is occupied and not transferring that edge, set `flush_pend=1`. This stalls pops.
  - While `flush_pend=1`, emit the partial word on the first edge the output register is free, then clear `flush_pend`.
  - `flush` while `flush_pend=1` is absorbed.
- `word_cnt` increments by 1 on each transfer.

## Timing
- Reset values: `rinc=0`, `m_valid=0`, `m_data=0`, `m_keep=0`, `word_cnt=0`. Internally `cnt=0`, `flush_pend=0`, assembly register = 0.
- Reset mid-operation discards any partial assembly and any pending or held output word. FIFO contents are untouched.
- Latency: `m_valid` rises the cycle after the edge that pops entry PACK-1 (or the edge that services a flush).
- Sustained throughput: 1 entry per `rclk` with `rempty=0` and `m_ready=1`, i.e. one word every PACK cycles with no bubbles.
- Backpressure: pops continue through lanes 0..PACK-2 while the output is stalled. The final-lane pop waits until the output is free or transferring on that edge.
- FIFO empty mid-word: `cnt` holds, and no output is produced until more data arrives or a flush occurs.

## Test plan
- FIFO preloaded with 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88, `m_ready=1`:
  - `rinc` high for 8 consecutive cycles;
  - `m_data=0x44332211` then `0x88776655`, both with `m_keep=4'hF`;
  - `word_cnt=2`.
- Same 8 entries with `m_ready=0` until cycle 10:
  - first word held stable;
  - exactly 7 pops occur before the stall;
  - the 8th pops on the edge `m_ready` rises;
  - the second word follows with no loss.
- Push 0xAA,0xBB, wait for empty, pulse `flush`:
  - `m_data=0x0000BBAA`, `m_keep=4'h3`, `cnt` returns to 0.
  - A further `flush` with `cnt=0` produces no word.
- `flush` on the same edge as the 3rd pop of 0x01,0x02,0x03 → `m_data=0x00030201`, `m_keep=4'h7`.
- `flush` while a full word is stalled (`m_ready=0`) with `cnt=2`:
  - `rinc` forced low even with `rempty=0`;
  - the partial word follows on the cycle after the full word is accepted.
- Assert `rrst` one cycle after the 2nd pop with `m_valid=1`:
  - all outputs return to reset values;
  - the next 4 entries form a clean word starting at lane 0;
  - `rinc` is never high while `rempty=1` throughout.
